// File: rtl/i2c_master_nco_writer.sv
// Single-master I2C writer that emits the NCO slave's write frame: address+W, control byte,
// then either eight frequency bytes or two duty bytes. The bus timing comes from a divider.
module i2c_master_nco_writer #(
  parameter logic [6:0]  ADDRESS = 7'b1101010,
  parameter int unsigned QDIV    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        enable_in,
  input  logic [1:0]  wave_in,
  input  logic        upd_freq,
  input  logic        upd_duty,
  input  logic [63:0] frequency_in,
  input  logic [15:0] duty_cycle_in,
  output logic        scl,
  inout  wire         sda,
  output logic        busy,
  output logic        done,
  output logic        nack,
  output logic        cmd_error
);
  localparam int PH_W = $clog2(QDIV);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP} state_t;

  state_t          state_q, state_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic [1:0]      qtr_q, qtr_d;
  logic [2:0]      bit_q, bit_d;
  logic [3:0]      byte_q, byte_d;
  logic [4:0]      ctrl_q, ctrl_d;
  logic [63:0]     freq_q, freq_d;
  logic [15:0]     duty_q, duty_d;
  logic            nack_q, nack_d;
  logic            done_q, done_d;
  logic            cerr_q, cerr_d;
  logic            scl_q, scl_d;
  logic            oe_q, oe_d;
  logic [1:0]      sda_sync_q;
  logic            phase_end;
  logic [3:0]      last_byte;
  logic [7:0]      tx_byte;

  function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic [4:0] ctrl,
                                            input logic [63:0] fr, input logic [15:0] dt);
    case (idx)
      4'd0:    return {ADDRESS, 1'b0};
      4'd1:    return {3'b000, ctrl};
      4'd2:    return ctrl[3] ? fr[63:56] : dt[15:8];
      4'd3:    return ctrl[3] ? fr[55:48] : dt[7:0];
      4'd4:    return fr[47:40];
      4'd5:    return fr[39:32];
      4'd6:    return fr[31:24];
      4'd7:    return fr[23:16];
      4'd8:    return fr[15:8];
      4'd9:    return fr[7:0];
      default: return 8'h00;
    endcase
  endfunction

  // Returns {scl, sda_oe} for a given state/quarter; sda_oe=1 pulls the line low.
  function automatic logic [1:0] bus_drive(input state_t st, input logic [1:0] qtr,
                                           input logic bitval);
    case (st)
      S_START: return {1'b1, qtr == 2'd1};
      S_BIT:   return {qtr[1], ~bitval};
      S_ACK:   return {qtr[1], 1'b0};
      S_STOP:  return {qtr != 2'd0, qtr != 2'd2};
      default: return 2'b10;
    endcase
  endfunction

  assign phase_end = (ph_q == PH_W'(QDIV - 1));
  assign last_byte = ctrl_q[3] ? 4'd9 : (ctrl_q[4] ? 4'd3 : 4'd1);

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    ctrl_d  = ctrl_q;
    freq_d  = freq_q;
    duty_d  = duty_q;
    nack_d  = nack_q;
    done_d  = 1'b0;
    cerr_d  = 1'b0;
    if (state_q != S_IDLE) ph_d = phase_end ? '0 : ph_q + PH_W'(1);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (upd_freq && upd_duty) begin
            cerr_d = 1'b1;
          end else begin
            state_d = S_START;
            ctrl_d  = {upd_duty, upd_freq, wave_in, enable_in};
            freq_d  = frequency_in;
            duty_d  = duty_cycle_in;
            nack_d  = 1'b0;
            qtr_d   = 2'd0;
            bit_d   = 3'd0;
            byte_d  = 4'd0;
            ph_d    = '0;
          end
        end
      end
      S_START: begin
        if (phase_end) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd1) begin
            state_d = S_BIT;
            qtr_d   = 2'd0;
          end
        end
      end
      S_BIT: begin
        if (phase_end) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd3) begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = S_ACK;
          end
        end
      end
      S_ACK: begin
        // Synchronised SDA is sampled once, on the first clk of the last quarter.
        if (qtr_q == 2'd3 && ph_q == '0 && sda_sync_q[1]) nack_d = 1'b1;
        if (phase_end) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd3) begin
            if (nack_q || byte_q == last_byte) begin
              state_d = S_STOP;
            end else begin
              state_d = S_BIT;
              byte_d  = byte_q + 4'd1;
            end
          end
        end
      end
      S_STOP: begin
        if (phase_end) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd2) begin
            state_d = S_IDLE;
            qtr_d   = 2'd0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Bus pins are decoded from next-state values so they leave straight from flops.
    tx_byte        = frame_byte(byte_d, ctrl_q, freq_q, duty_q);
    {scl_d, oe_d}  = bus_drive(state_d, qtr_d, tx_byte[3'd7 - bit_d]);
  end

  always_ff @(posedge clk) begin
    ctrl_q <= ctrl_d;
    freq_q <= freq_d;
    duty_q <= duty_d;
    if (!reset) begin
      state_q    <= S_IDLE;
      ph_q       <= '0;
      qtr_q      <= 2'd0;
      bit_q      <= 3'd0;
      byte_q     <= 4'd0;
      nack_q     <= 1'b0;
      done_q     <= 1'b0;
      cerr_q     <= 1'b0;
      scl_q      <= 1'b1;
      oe_q       <= 1'b0;
      sda_sync_q <= 2'b11;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      qtr_q      <= qtr_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      nack_q     <= nack_d;
      done_q     <= done_d;
      cerr_q     <= cerr_d;
      scl_q      <= scl_d;
      oe_q       <= oe_d;
      sda_sync_q <= {sda_sync_q[0], sda};
    end
  end

  assign scl       = scl_q;
  assign sda       = oe_q ? 1'b0 : 1'bz;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign nack      = nack_q;
  assign cmd_error = cerr_q;
endmodule

// File: tb/tb_i2c_master_nco_writer.sv
// Directed bench for i2c_master_nco_writer with a bus-level NCO slave model and START/STOP monitor.
module tb_i2c_master_nco_writer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        enable_in = 1'b0;
  logic [1:0]  wave_in = 2'b00;
  logic        upd_freq = 1'b0;
  logic        upd_duty = 1'b0;
  logic [63:0] frequency_in = '0;
  logic [15:0] duty_cycle_in = '0;
  logic        scl, busy, done, nack, cmd_error;
  wire         sda;

  logic        ack_drv = 1'b0;
  logic        respond = 1'b1;
  logic [7:0]  rx[$];
  int          n_start = 0, n_stop = 0;
  logic [63:0] nco_freq = '0;
  logic [15:0] nco_duty = '0;
  logic [7:0]  nco_ctrl = '0;
  int          n_chk = 0, n_err = 0;

  pullup (sda);
  assign sda = ack_drv ? 1'b0 : 1'bz;

  i2c_master_nco_writer #(.ADDRESS(7'b1101010), .QDIV(4)) dut (
    .clk(clk), .reset(reset), .start(start), .enable_in(enable_in), .wave_in(wave_in),
    .upd_freq(upd_freq), .upd_duty(upd_duty), .frequency_in(frequency_in),
    .duty_cycle_in(duty_cycle_in), .scl(scl), .sda(sda), .busy(busy), .done(done),
    .nack(nack), .cmd_error(cmd_error)
  );

  always #5 clk = ~clk;

  // Slave model: samples the bus mid-cycle, ACKs when respond=1, and loads NCO registers.
  initial begin
    logic scl_p, sda_p;
    logic [7:0] sh;
    int bitcnt;
    scl_p = 1'b1; sda_p = 1'b1; sh = '0; bitcnt = 0;
    forever begin
      @(negedge clk);
      if (scl_p && scl && sda_p && !sda) begin
        n_start++; bitcnt = 0;
      end else if (scl_p && scl && !sda_p && sda) begin
        n_stop++; bitcnt = 0; ack_drv = 1'b0;
      end else if (!scl_p && scl) begin
        if (bitcnt < 8) sh = {sh[6:0], sda};
        bitcnt++;
        if (bitcnt == 8) begin
          rx.push_back(sh);
          if (rx.size() == 2) nco_ctrl = sh;
          else if (rx.size() > 2 && nco_ctrl[3]) nco_freq = {nco_freq[55:0], sh};
          else if (rx.size() > 2 && nco_ctrl[4]) nco_duty = {nco_duty[7:0], sh};
        end
      end else if (scl_p && !scl) begin
        if (bitcnt == 8 && respond) ack_drv = 1'b1;
        else if (bitcnt == 9) begin ack_drv = 1'b0; bitcnt = 0; end
      end
      scl_p = scl; sda_p = sda;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_sb();
    rx.delete();
    n_start = 0;
    n_stop  = 0;
  endtask

  task automatic launch(input logic en, input logic [1:0] wv, input logic uf, input logic ud,
                        input logic [63:0] fr, input logic [15:0] dt);
    @(negedge clk);
    enable_in = en; wave_in = wv; upd_freq = uf; upd_duty = ud;
    frequency_in = fr; duty_cycle_in = dt; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 4000 && done !== 1'b1) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("done_seen", done, 1'b1);
  endtask

  task automatic run_xfer(input logic en, input logic [1:0] wv, input logic uf, input logic ud,
                          input logic [63:0] fr, input logic [15:0] dt, output int cyc);
    launch(en, wv, uf, ud, fr, dt);
    wait_done(cyc);
  endtask

  initial begin
    int cyc, bad;
    logic [7:0] fexp[10];
    fexp = '{8'hD4, 8'h08, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl", scl, 1'b1);
    chk("rst_sda", sda, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_nack", nack, 1'b0);
    chk("rst_cerr", cmd_error, 1'b0);
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);

    // Control-only write, with a retried start and changed inputs while busy.
    clear_sb();
    fork
      run_xfer(1'b1, 2'b10, 1'b0, 1'b0, 64'h0, 16'h0, cyc);
      begin
        repeat (50) @(negedge clk);
        enable_in = 1'b0; wave_in = 2'b01; upd_duty = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    chk("ctl_cycles", cyc, 308);
    chk("ctl_nbytes", rx.size(), 2);
    chk("ctl_b0", rx[0], 8'hD4);
    chk("ctl_b1", rx[1], 8'h05);
    chk("ctl_nack", nack, 1'b0);
    chk("ctl_busy_end", busy, 1'b0);
    chk("ctl_starts", n_start, 1);
    chk("ctl_stops", n_stop, 1);
    @(posedge clk); #1;
    chk("ctl_done_pulse", done, 1'b0);
    upd_duty = 1'b0;

    // Frequency write.
    clear_sb();
    run_xfer(1'b0, 2'b00, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 16'h0, cyc);
    chk("frq_cycles", cyc, 1460);
    chk("frq_nbytes", rx.size(), 10);
    for (int i = 0; i < 10; i++) chk($sformatf("frq_b%0d", i), rx[i], fexp[i]);
    chk("frq_nco_reg", nco_freq, 64'h0123_4567_89AB_CDEF);
    chk("frq_nack", nack, 1'b0);

    // Duty write; any SDA edge under high SCL would show up as an extra START/STOP.
    clear_sb();
    run_xfer(1'b0, 2'b00, 1'b0, 1'b1, 64'h0, 16'h8000, cyc);
    chk("dty_cycles", cyc, 596);
    chk("dty_nbytes", rx.size(), 4);
    chk("dty_b0", rx[0], 8'hD4);
    chk("dty_b1", rx[1], 8'h10);
    chk("dty_b2", rx[2], 8'h80);
    chk("dty_b3", rx[3], 8'h00);
    chk("dty_nco_reg", nco_duty, 16'h8000);
    chk("dty_starts", n_start, 1);
    chk("dty_stops", n_stop, 1);

    // Address NACK: no responder.
    clear_sb();
    respond = 1'b0;
    run_xfer(1'b1, 2'b00, 1'b0, 1'b0, 64'h0, 16'h0, cyc);
    chk("nak_cycles", cyc, 164);
    chk("nak_flag", nack, 1'b1);
    chk("nak_nbytes", rx.size(), 1);
    chk("nak_b0", rx[0], 8'hD4);
    chk("nak_starts", n_start, 1);
    chk("nak_stops", n_stop, 1);
    respond = 1'b1;

    // Illegal request.
    clear_sb();
    launch(1'b1, 2'b00, 1'b1, 1'b1, 64'h0, 16'h0);
    upd_freq = 1'b0; upd_duty = 1'b0;
    chk("ill_cerr", cmd_error, 1'b1);
    chk("ill_busy", busy, 1'b0);
    @(posedge clk); #1;
    chk("ill_cerr_1cyc", cmd_error, 1'b0);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (scl !== 1'b1 || sda !== 1'b1 || busy !== 1'b0) bad = 1;
    end
    chk("ill_bus_idle", bad, 0);
    chk("ill_no_start", n_start, 0);

    // Reset in the middle of byte 3.
    clear_sb();
    launch(1'b1, 2'b11, 1'b1, 1'b0, 64'hFFFF_0000_FFFF_0000, 16'h0);
    cyc = 0;
    while (rx.size() < 2 && cyc < 2000) begin @(negedge clk); cyc++; end
    chk("rmf_reached_b3", rx.size() >= 2, 1'b1);
    repeat (40) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rmf_scl", scl, 1'b1);
    chk("rmf_sda", sda, 1'b1);
    chk("rmf_busy", busy, 1'b0);
    chk("rmf_done", done, 1'b0);
    @(negedge clk) reset = 1'b1;
    bad = 0;
    repeat (400) begin
      @(negedge clk);
      if (done !== 1'b0) bad = 1;
    end
    chk("rmf_no_done", bad, 0);
    clear_sb();
    run_xfer(1'b1, 2'b10, 1'b0, 1'b0, 64'h0, 16'h0, cyc);
    chk("rmf_re_cycles", cyc, 308);
    chk("rmf_re_nbytes", rx.size(), 2);
    chk("rmf_re_b0", rx[0], 8'hD4);
    chk("rmf_re_b1", rx[1], 8'h05);
    chk("rmf_re_nack", nack, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/i2c_master_nco_writer.md
Name: i2c_master_nco_writer

Overview:
- I2C master that writes NCO configuration (enable, waveform, 64-bit frequency, 16-bit duty cycle) to the NCO's I2C slave.
- Sits on the controller/test side of the bus and produces the slave's exact write frame: address+W, control byte, then optional frequency bytes or optional duty bytes.
- Single master, standard-mode style timing from a clock divider, no clock stretching, no arbitration.

Parameters:
ADDRESS, 7'b1101010, 7-bit target slave address.
QDIV, 4, clk cycles per quarter SCL bit period. Legal minimum is 2.

Ports:
clk  input  1  System clock.
reset  input  1  Synchronous reset, active-low.
start  input  1  Single-cycle request. Sampled only in IDLE.
enable_in  input  1  Control byte bit 0.
wave_in  input  2  Control byte bits 2:1.
upd_freq  input  1  Control byte bit 3. When set, 8 frequency bytes follow.
upd_duty  input  1  Control byte bit 4. When set, 2 duty bytes follow.
frequency_in  input  64  Frequency word, sent MSB byte first.
duty_cycle_in  input  16  Duty word, sent MSB byte first.
scl  output  1  I2C clock, push-pull, idles 1.
sda  inout  1  I2C data, open-drain: driven 0 when sda_oe=1, else z.
busy  output  1  High from the accepted start until the done pulse.
done  output  1  One-cycle pulse at the end of a transfer.
nack  output  1  Valid with done: 1 = a NACK was received.
cmd_error  output  1  One-cycle pulse when start is rejected.

Behaviour:
- Reset (reset==0 at posedge clk):
  - State returns to IDLE. scl=1, sda released.
  - busy=0, done=0, nack=0, cmd_error=0. All counters cleared.
  - Reset mid-transfer aborts immediately. No STOP is generated.
- Input capture: on start in IDLE, all data inputs are latched. Later input changes have no effect on the transfer in progress.
- Rejected requests:
  - start with upd_freq=1 and upd_duty=1 gives cmd_error=1 for one cycle. No bus activity, busy stays 0.
  - start while busy is ignored.
- Control byte: {3'b000, upd_duty, upd_freq, wave_in, enable_in}.
- Frame byte sequence, N bytes in total:
  - ADDR = {ADDRESS, 1'b0}.
  - CTRL.
  - If upd_freq: frequency[63:56] first, down to [7:0]. N=10.
  - If upd_duty: duty[15:8], then [7:0]. N=4.
  - If neither: N=2.
- Timing unit: phase = QDIV clk cycles, counted by a phase counter.
- START (2 phases):
  - P0: scl=1, sda released.
  - P1: scl=1, sda=0.
- Data bit (4 phases; bits sent MSB first):
  - Q0: scl=0, sda set to the bit value.
  - Q1: scl=0.
  - Q2: scl=1.
  - Q3: scl=1.
  - SDA changes only while scl=0.
- ACK bit (9th bit of each byte, 4 phases):
  - sda released in Q0.
  - sda synchronised through 2 flops and sampled on the first clk of Q3.
  - Sampled 1 means NACK: the nack flag is set and the remaining bytes are skipped; after Q3 the FSM goes to STOP.
- STOP (3 phases):
  - S0: scl=0, sda=0.
  - S1: scl=1, sda=0.
  - S2: scl=1, sda released.
  - After S2 the FSM returns to IDLE: done=1 for one cycle, busy=0, nack reflects the flag. nack clears on the next accepted start.
- State machine:
  - IDLE -> START on an accepted start.
  - START -> BIT.
  - BIT -> ACK after 8 bits.
  - ACK -> BIT if ACK received and bytes remain.
  - ACK -> STOP if NACK or last byte.
  - STOP -> IDLE.
- Transfer length, start acceptance to done: QDIV*(5 + 36*N) cycles.
  - QDIV=4: N=2 gives 308 cycles, N=4 gives 596, N=10 gives 1460.
- No-ACK case (line pulled up, no slave): NACK on the address byte, then STOP. Total QDIV*(5+36) cycles.
- A start in the same cycle as done (state still STOP) is ignored. A start the cycle after done is accepted.

Test Plan:
- Control-only write: QDIV=4, enable_in=1, wave_in=2'b10, both upd=0; bus model ACKs every byte -> bus bytes 0xD4, 0x05; done exactly 308 cycles after start; nack=0.
- Frequency write: upd_freq=1, frequency_in=64'h0123_4567_89AB_CDEF, enable_in=0, wave_in=0 -> bytes 0xD4, 0x08, 01, 23, 45, 67, 89, AB, CD, EF; done at 1460 cycles; the NCO slave model's internal frequency register reads 64'h0123456789ABCDEF.
- Duty write: upd_duty=1, duty_cycle_in=16'h8000 -> bytes 0xD4, 0x10, 0x80, 0x00; done at 596 cycles; SDA never toggles while scl=1 except at START and STOP.
- Address NACK: no responder on the bus -> one byte plus ACK clock, then STOP; done with nack=1 after 164 cycles; start/stop detector counts exactly one START and one STOP.
- Illegal request: upd_freq=1 and upd_duty=1 -> cmd_error pulse 1 cycle; scl and sda stay 1; busy=0. A second start while busy during a valid transfer changes nothing.
- Reset mid-frame: reset=0 during byte 3 -> next cycle scl=1, sda=z, busy=0, no done pulse; a new start afterwards produces a correct complete frame.
